// File: rtl/int_sequencer.sv
// Interrupt-entry sequencer: freezes the PC, drains the pipeline, pushes the
// interrupted PC as two 16-bit words, fetches the ISR vector and redirects.
module int_sequencer #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] VEC_ADDR     = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] sp_in,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [31:0] sp_out,
  output logic        sp_we,
  output logic        pc_hold,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        int_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    VEC_HI,
    VEC_LO,
    REDIRECT
  } state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state;
  logic          int_prev;
  logic          pending;
  logic [31:0]   pc_saved;
  logic [31:0]   vec;
  logic [CW-1:0] drain_cnt;
  logic          trigger;

  assign trigger = int_req & ~int_prev;

  // A trigger that arrives while a sequence is in flight is remembered once
  // and picked up on the first IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      int_prev  <= 1'b0;
      pending   <= 1'b0;
      pc_saved  <= 32'd0;
      vec       <= 32'd0;
      drain_cnt <= '0;
    end else begin
      int_prev <= int_req;
      if (trigger && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger || pending) begin
            pc_saved  <= pc_in;
            pending   <= 1'b0;
            drain_cnt <= '0;
            state     <= (DRAIN_CYCLES == 0) ? PUSH_HI : DRAIN;
          end
        end
        DRAIN: begin
          if (int'(drain_cnt) >= DRAIN_CYCLES - 1) state <= PUSH_HI;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        PUSH_HI: begin
          if (mem_ready) state <= PUSH_LO;
        end
        PUSH_LO: begin
          if (mem_ready) state <= VEC_HI;
        end
        VEC_HI: begin
          if (mem_ready) begin
            vec[31:16] <= mem_rdata;
            state      <= VEC_LO;
          end
        end
        VEC_LO: begin
          if (mem_ready) begin
            vec[15:0] <= mem_rdata;
            state     <= REDIRECT;
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register only (plus mem_ready for the
  // SP write strobe), so an asynchronous reset clears them immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 16'd0;
    sp_out    = 32'd0;
    sp_we     = 1'b0;
    pc_load   = 1'b0;
    pc_target = 32'd0;
    int_ack   = 1'b0;
    case (state)
      PUSH_HI: begin
        mem_we    = 1'b1;
        mem_addr  = sp_in;
        mem_wdata = pc_saved[31:16];
      end
      PUSH_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_in - 32'd1;
        mem_wdata = pc_saved[15:0];
        sp_out    = sp_in - 32'd2;
        sp_we     = mem_ready;
      end
      VEC_HI: begin
        mem_re   = 1'b1;
        mem_addr = VEC_ADDR;
      end
      VEC_LO: begin
        mem_re   = 1'b1;
        mem_addr = VEC_ADDR + 32'd1;
      end
      REDIRECT: begin
        pc_load   = 1'b1;
        int_ack   = 1'b1;
        pc_target = vec;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign pc_hold = busy;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer: default-drain instance plus
// a zero-drain instance with a wrapping vector address.
module tb_int_sequencer;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic [31:0] pc_in;
  logic [31:0] sp_in;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_we, mem_re, sp_we, pc_hold, pc_load, int_ack, busy;
  logic [31:0] mem_addr, sp_out, pc_target;
  logic [15:0] mem_wdata;

  logic        int_req_z;
  logic [31:0] pc_in_z;
  logic [31:0] sp_in_z;
  logic        mem_ready_z;
  logic [15:0] mem_rdata_z;
  logic        mem_we_z, mem_re_z, sp_we_z, pc_hold_z, pc_load_z, int_ack_z, busy_z;
  logic [31:0] mem_addr_z, sp_out_z, pc_target_z;
  logic [15:0] mem_wdata_z;

  int checks;
  int failures;
  int load_count;

  int_sequencer #(.DRAIN_CYCLES(3), .VEC_ADDR(32'd0)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .pc_in(pc_in), .sp_in(sp_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_out(sp_out), .sp_we(sp_we),
    .pc_hold(pc_hold), .pc_load(pc_load), .pc_target(pc_target), .int_ack(int_ack),
    .busy(busy)
  );

  int_sequencer #(.DRAIN_CYCLES(0), .VEC_ADDR(32'hFFFF_FFFF)) dut_z (
    .clk(clk), .reset(reset), .int_req(int_req_z), .pc_in(pc_in_z), .sp_in(sp_in_z),
    .mem_ready(mem_ready_z), .mem_rdata(mem_rdata_z), .mem_we(mem_we_z), .mem_re(mem_re_z),
    .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z), .sp_out(sp_out_z), .sp_we(sp_we_z),
    .pc_hold(pc_hold_z), .pc_load(pc_load_z), .pc_target(pc_target_z), .int_ack(int_ack_z),
    .busy(busy_z)
  );

  // Vector memory: word 0 = 0x0000, word 1 = 0x0120 for the main instance;
  // 0xFFFFFFFF = 0xABCD, 0 = 0x1234 for the wrapping instance.
  assign mem_rdata   = !mem_re ? 16'h0000 :
                       (mem_addr == 32'd0) ? 16'h0000 :
                       (mem_addr == 32'd1) ? 16'h0120 : 16'hBAD0;
  assign mem_rdata_z = !mem_re_z ? 16'h0000 :
                       (mem_addr_z == 32'hFFFF_FFFF) ? 16'hABCD :
                       (mem_addr_z == 32'd0) ? 16'h1234 : 16'hBAD1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (pc_load) load_count++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full entry sequence starting from IDLE, with mem_ready held low for
  // 'stall' cycles at the start of PUSH_HI. Called at a cycle boundary.
  task automatic applyStimulus(input int stall);
    int d;
    d = stall;
    pc_in = 32'h0000_0042;
    sp_in = 32'h0000_07FF;
    mem_ready = 1'b1;
    int_req = 1'b1;
    for (int c = 1; c <= 9 + d; c++) begin
      tick();
      int_req = 1'b0;
      pc_in = 32'hDEAD_BEEF;
      mem_ready = !(c >= 4 && c < 4 + d);
      #1;
      checkOutput("busy", {31'd0, busy}, {31'd0, c <= 8 + d});
      checkOutput("pc_hold", {31'd0, pc_hold}, {31'd0, c <= 8 + d});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, c >= 4 && c <= 5 + d});
      checkOutput("mem_re", {31'd0, mem_re}, {31'd0, c == 6 + d || c == 7 + d});
      checkOutput("sp_we", {31'd0, sp_we}, {31'd0, c == 5 + d});
      checkOutput("pc_load", {31'd0, pc_load}, {31'd0, c == 8 + d});
      checkOutput("int_ack", {31'd0, int_ack}, {31'd0, c == 8 + d});
      if (c >= 4 && c <= 4 + d) begin
        checkOutput("push_hi_addr", mem_addr, 32'h0000_07FF);
        checkOutput("push_hi_data", {16'd0, mem_wdata}, 32'h0000_0000);
      end
      if (c == 5 + d) begin
        checkOutput("push_lo_addr", mem_addr, 32'h0000_07FE);
        checkOutput("push_lo_data", {16'd0, mem_wdata}, 32'h0000_0042);
        checkOutput("sp_out", sp_out, 32'h0000_07FD);
      end
      if (c == 6 + d) checkOutput("vec_hi_addr", mem_addr, 32'h0000_0000);
      if (c == 7 + d) checkOutput("vec_lo_addr", mem_addr, 32'h0000_0001);
      if (c == 8 + d) checkOutput("pc_target", pc_target, 32'h0000_0120);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    load_count = 0;
    reset = 1'b0;
    int_req = 1'b0;
    pc_in = 32'd0;
    sp_in = 32'd0;
    mem_ready = 1'b1;
    int_req_z = 1'b0;
    pc_in_z = 32'd0;
    sp_in_z = 32'd0;
    mem_ready_z = 1'b1;

    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_pc_load", {31'd0, pc_load}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_busy_z", {31'd0, busy_z}, 32'd0);
    reset = 1'b1;
    tick();
    tick();

    $display("[TB] basic sequence");
    applyStimulus(0);
    tick();

    $display("[TB] PUSH_HI stalled 4 cycles");
    applyStimulus(4);
    tick();

    // Edge during DRAIN queues one extra sequence; the edge during VEC_LO is dropped.
    $display("[TB] pending interrupts");
    load_count = 0;
    pc_in = 32'h0000_0042;
    sp_in = 32'h0000_07FF;
    int_req = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      int_req = (c == 2 || c == 7);
      #1;
      if (c == 9) checkOutput("pend_idle_gap", {31'd0, busy}, 32'd0);
      if (c == 10) checkOutput("pend_restart", {31'd0, busy}, 32'd1);
      if (c == 17) checkOutput("pend_second_load", {31'd0, pc_load}, 32'd1);
    end
    checkOutput("pend_load_count", load_count, 32'd2);

    $display("[TB] level held high");
    load_count = 0;
    int_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      int_req = (c < 20);
      #1;
      if (c == 10) checkOutput("level_idle", {31'd0, busy}, 32'd0);
    end
    checkOutput("level_load_count", load_count, 32'd1);

    $display("[TB] reset during VEC_HI");
    load_count = 0;
    int_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      int_req = 1'b0;
      #1;
    end
    checkOutput("abort_in_vec_hi", {31'd0, mem_re}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_mem_re", {31'd0, mem_re}, 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) tick();
    checkOutput("abort_no_load", load_count, 32'd0);
    applyStimulus(0);
    checkOutput("abort_rerun_load", load_count, 32'd1);
    tick();

    $display("[TB] zero drain, wrapping addresses");
    pc_in_z = 32'h89AB_CDEF;
    sp_in_z = 32'd0;
    int_req_z = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      int_req_z = 1'b0;
      pc_in_z = 32'h1111_1111;
      #1;
      checkOutput("z_busy", {31'd0, busy_z}, {31'd0, c <= 5});
      checkOutput("z_sp_we", {31'd0, sp_we_z}, {31'd0, c == 2});
      checkOutput("z_pc_load", {31'd0, pc_load_z}, {31'd0, c == 5});
      if (c == 1) begin
        checkOutput("z_push_hi_we", {31'd0, mem_we_z}, 32'd1);
        checkOutput("z_push_hi_addr", mem_addr_z, 32'h0000_0000);
        checkOutput("z_push_hi_data", {16'd0, mem_wdata_z}, 32'h0000_89AB);
      end
      if (c == 2) begin
        checkOutput("z_push_lo_addr", mem_addr_z, 32'hFFFF_FFFF);
        checkOutput("z_push_lo_data", {16'd0, mem_wdata_z}, 32'h0000_CDEF);
        checkOutput("z_sp_out", sp_out_z, 32'hFFFF_FFFE);
      end
      if (c == 3) checkOutput("z_vec_hi_addr", mem_addr_z, 32'hFFFF_FFFF);
      if (c == 4) checkOutput("z_vec_lo_addr", mem_addr_z, 32'h0000_0000);
      if (c == 5) checkOutput("z_pc_target", pc_target_z, 32'hABCD_1234);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Interrupt-entry sequencer that produces the redirect inputs the program counter consumes on an interrupt.
- On an external interrupt it:
  - freezes the PC,
  - waits for the pipeline to drain,
  - pushes the interrupted PC onto the stack as two 16-bit words,
  - reads a 32-bit ISR vector from data memory,
  - issues a one-cycle PC load to the ISR address.
- Sits between the interrupt pin, the data-memory port arbiter and the program counter.

Parameters:
- DRAIN_CYCLES, 3, cycles waited after trigger before the first memory access (0 allowed).
- VEC_ADDR, 32'd0, word address of vector high half; low half at VEC_ADDR+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- int_req  input  1  external interrupt request, level; a rising edge triggers entry.
- pc_in  input  32  current PC value from the program counter.
- sp_in  input  32  current stack pointer (word address of next free slot).
- mem_ready  input  1  memory accepts the current access this cycle; read data valid.
- mem_rdata  input  16  read data, valid when mem_re and mem_ready are both 1.
- mem_we  output  1  write request.
- mem_re  output  1  read request.
- mem_addr  output  32  access address.
- mem_wdata  output  16  write data.
- sp_out  output  32  new stack pointer.
- sp_we  output  1  one-cycle pulse: load sp_out into SP.
- pc_hold  output  1  stall to the program counter.
- pc_load  output  1  one-cycle pulse: load pc_target.
- pc_target  output  32  ISR address.
- int_ack  output  1  one-cycle pulse coincident with pc_load.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; all outputs 0; edge register, pending flag, saved PC, vector register and drain counter cleared.
  - Reset mid-sequence aborts with no further memory access or SP update.
- Edge detect: int_prev registered each cycle; trigger = int_req & ~int_prev.
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, VEC_HI, VEC_LO, REDIRECT.
- IDLE:
  - On trigger or pending=1: capture pc_saved = pc_in, clear pending.
  - Next state is DRAIN, or PUSH_HI if DRAIN_CYCLES=0.
- DRAIN: stays exactly DRAIN_CYCLES cycles, then PUSH_HI.
- PUSH_HI:
  - mem_we=1, mem_addr=sp_in, mem_wdata=pc_saved[31:16].
  - Held stable until mem_ready=1; then PUSH_LO.
- PUSH_LO:
  - mem_we=1, mem_addr=sp_in-1, mem_wdata=pc_saved[15:0].
  - On mem_ready: sp_we pulse with sp_out=sp_in-2; then VEC_HI.
- VEC_HI: mem_re=1, mem_addr=VEC_ADDR; on mem_ready, vec[31:16]=mem_rdata; then VEC_LO.
- VEC_LO: mem_re=1, mem_addr=VEC_ADDR+1; on mem_ready, vec[15:0]=mem_rdata; then REDIRECT.
- REDIRECT: pc_load=1, int_ack=1, pc_target=vec, for one cycle; then IDLE.
- All outputs are registered/state-decoded.
- pc_hold = busy = (state != IDLE).
- mem_we and mem_re are never both 1.
- With mem_ready=0 the FSM waits indefinitely, holding addr/data stable; there is no timeout.
- Arithmetic is modulo 2^32:
  - sp_in=0 gives PUSH_LO address 32'hFFFFFFFF and sp_out 32'hFFFFFFFE.
  - VEC_ADDR=32'hFFFFFFFF gives low-half address 0.
- A trigger while busy sets pending. Only one level is kept; further edges are dropped. Pending is serviced on the first IDLE cycle.
- A trigger in the same cycle as REDIRECT sets pending.
- sp_in and pc_in are not re-sampled mid-sequence except sp_in, which must stay stable while busy (the pipeline is frozen).
- Latency (DRAIN_CYCLES=3, mem_ready=1), trigger sampled at edge 0:
  - DRAIN in cycles 1-3
  - PUSH_HI in cycle 4
  - PUSH_LO and sp_we in cycle 5
  - VEC_HI in cycle 6
  - VEC_LO in cycle 7
  - pc_load in cycle 8
  - IDLE in cycle 9

Test Plan:
- Reset, then int_req 0->1 with pc_in=0x00000042, sp_in=0x000007FF, memory[0]=0x0000, memory[1]=0x0120, mem_ready=1 -> writes 0x0000@0x7FF and 0x0042@0x7FE; sp_we with sp_out=0x7FD in cycle 5; pc_load with pc_target=0x00000120 in cycle 8; pc_hold high cycles 1-8.
- Same stimulus, mem_ready low 4 cycles during PUSH_HI -> mem_addr/mem_wdata/mem_we held stable; every later event delayed by exactly 4 cycles.
- Second int_req edge in DRAIN plus a third edge in VEC_LO -> exactly one extra sequence starts the cycle after return to IDLE; total of two pc_load pulses.
- int_req held high 20 cycles -> exactly one sequence.
- reset asserted during VEC_HI -> outputs 0 asynchronously, no pc_load; the next edge after release runs a full sequence.
- DRAIN_CYCLES=0, sp_in=0 -> PUSH_HI in cycle 1; addresses 0x00000000 and 0xFFFFFFFF; sp_out=0xFFFFFFFE.
